// File: rtl/float_to_int_pkg.sv
// rtl/float_to_int_pkg.sv - shared FSM encoding and flag bit indices for float_to_int_conv
package float_to_int_pkg;

  // Conversion sequence: GET_A -> UNPACK -> SPECIAL -> (CONVERT)* -> ROUND -> PUT_Z
  typedef enum logic [2:0] {
    ST_GET_A,
    ST_UNPACK,
    ST_SPECIAL,
    ST_CONVERT,
    ST_ROUND,
    ST_PUT_Z
  } state_t;

  // Bit positions inside output_z_flags
  localparam int FLAG_INVALID = 1;
  localparam int FLAG_INEXACT = 0;

endpackage

// File: rtl/float_to_int_round.sv
// rtl/float_to_int_round.sv - combinational round, range check, negate and saturate stage
// Purpose: turns the aligned integer magnitude plus round/sticky bits into the final
//   two's-complement or unsigned result and its flags.
// Ports:
//   i_m        aligned integer magnitude (binary point just below bit 0)
//   i_r, i_s   round bit and sticky bit below i_m
//   i_sign     operand sign
//   i_unsigned 1 = unsigned result requested
//   o_z        integer result
//   o_flags    {invalid, inexact}
// Build option: FLOAT_TO_INT_RNE_EN selects round-to-nearest-even, otherwise truncation.
module float_to_int_round
  import float_to_int_pkg::*;
#(
  parameter int INT_W = 64
) (
  input  logic [INT_W-1:0] i_m,
  input  logic             i_r,
  input  logic             i_s,
  input  logic             i_sign,
  input  logic             i_unsigned,
  output logic [INT_W-1:0] o_z,
  output logic [1:0]       o_flags
);

  localparam logic [INT_W-1:0] MIN_INT = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] MAX_INT = {1'b0, {(INT_W-1){1'b1}}};

  logic             w_rnd;
  logic [INT_W:0]   w_mag;  // bit INT_W is the rounding carry

`ifdef FLOAT_TO_INT_RNE_EN
  assign w_rnd = i_r & (i_s | i_m[0]);
`else
  assign w_rnd = 1'b0;
`endif

  assign w_mag = {1'b0, i_m} + {{INT_W{1'b0}}, w_rnd};

  always_comb begin
    o_z                   = w_mag[INT_W-1:0];
    o_flags               = '0;
    o_flags[FLAG_INEXACT] = i_r | i_s;
    if (i_unsigned) begin
      if (i_sign && (w_mag != '0)) begin
        o_z                   = '0;
        o_flags               = '0;
        o_flags[FLAG_INVALID] = 1'b1;
      end else if (w_mag[INT_W]) begin
        o_z                   = '1;
        o_flags               = '0;
        o_flags[FLAG_INVALID] = 1'b1;
      end
    end else begin
      // A magnitude of exactly 2^(INT_W-1) is only representable when negative.
      if (w_mag[INT_W] ||
          (w_mag[INT_W-1] && !(i_sign && (w_mag[INT_W-1:0] == MIN_INT)))) begin
        o_z                   = i_sign ? MIN_INT : MAX_INT;
        o_flags               = '0;
        o_flags[FLAG_INVALID] = 1'b1;
      end else if (i_sign) begin
        o_z = -w_mag[INT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/float_to_int_conv.sv
// rtl/float_to_int_conv.sv - parametrised IEEE-754 float to signed/unsigned integer converter
// Purpose: stb/ack wrapped multi-cycle converter; one right shift per CONVERT cycle aligns the
//   mantissa, then float_to_int_round produces the saturated result and {invalid, inexact} flags.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   input_a, input_a_unsigned         operand {sign, exp, frac} and unsigned-result select
//   input_a_stb / input_a_ack         operand handshake
//   output_z, output_z_flags          result and {invalid, inexact}
//   output_z_stb / output_z_ack       result handshake
// Build option: FLOAT_TO_INT_RNE_EN (see float_to_int_round).
module float_to_int_conv
  import float_to_int_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  parameter int INT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] input_a,
  input  logic                 input_a_unsigned,
  input  logic                 input_a_stb,
  output logic                 input_a_ack,
  output logic [INT_W-1:0]     output_z,
  output logic [1:0]           output_z_flags,
  output logic                 output_z_stb,
  input  logic                 output_z_ack
);

  localparam int EXT = ((MAN_W + 1) > INT_W) ? (MAN_W + 1) : INT_W;
  localparam logic signed [EXP_W:0] BIAS   = {2'b00, {(EXP_W-1){1'b1}}};
  localparam logic signed [EXP_W:0] E_TOP  = (EXP_W+1)'(INT_W - 1);
  localparam logic signed [EXP_W:0] E_NEG1 = '1;
  localparam logic signed [EXP_W:0] E_ONE  = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [INT_W-1:0] MIN_INT = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] MAX_INT = {1'b0, {(INT_W-1){1'b1}}};

  state_t                   r_state, w_next;
  logic [EXP_W+MAN_W:0]     r_a;
  logic                     r_uns;
  logic signed [EXP_W:0]    r_e;
  logic [INT_W-1:0]         r_m;
  logic                     r_r, r_s;
  logic                     r_ack, r_stb;
  logic [INT_W-1:0]         r_z;
  logic [1:0]               r_flags;

  logic                     w_sign;
  logic [EXP_W-1:0]         w_exp;
  logic [MAN_W-1:0]         w_frac;
  logic [EXT+1:0]           w_ext;
  logic                     w_special;
  logic [INT_W-1:0]         w_sat_z, w_sp_z, w_rd_z;
  logic [1:0]               w_sp_flags, w_rd_flags;

  assign w_sign = r_a[EXP_W+MAN_W];
  assign w_exp  = r_a[EXP_W+MAN_W-1:MAN_W];
  assign w_frac = r_a[MAN_W-1:0];
  // {1,frac} left-justified with at least two spare bits below the INT_W window,
  // so the round bit and sticky bits always exist.
  assign w_ext  = {1'b1, w_frac, {(EXT+1-MAN_W){1'b0}}};

  always_comb begin
    w_sat_z    = w_sign ? (r_uns ? '0 : MIN_INT) : (r_uns ? '1 : MAX_INT);
    w_special  = 1'b1;
    w_sp_z     = '0;
    w_sp_flags = '0;
    if (w_exp == '1) begin
      w_sp_z                   = (w_frac != '0) ? (r_uns ? '0 : MIN_INT) : w_sat_z;
      w_sp_flags[FLAG_INVALID] = 1'b1;
    end else if (w_exp == '0) begin
      w_sp_flags[FLAG_INEXACT] = (w_frac != '0);
    end else if (r_e > E_TOP) begin
      w_sp_z                   = w_sat_z;
      w_sp_flags[FLAG_INVALID] = 1'b1;
    end else if (r_e < E_NEG1) begin
      w_sp_flags[FLAG_INEXACT] = 1'b1;
    end else begin
      w_special = 1'b0;
    end
  end

  float_to_int_round #(.INT_W(INT_W)) u_round (
    .i_m        (r_m),
    .i_r        (r_r),
    .i_s        (r_s),
    .i_sign     (w_sign),
    .i_unsigned (r_uns),
    .o_z        (w_rd_z),
    .o_flags    (w_rd_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_GET_A;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_GET_A:   if (r_ack && input_a_stb) w_next = ST_UNPACK;
      ST_UNPACK:  w_next = ST_SPECIAL;
      ST_SPECIAL: w_next = w_special ? ST_PUT_Z : ST_CONVERT;
      ST_CONVERT: if (r_e >= E_TOP) w_next = ST_ROUND;
      ST_ROUND:   w_next = ST_PUT_Z;
      ST_PUT_Z:   if (r_stb && output_z_ack) w_next = ST_GET_A;
      default:    w_next = ST_GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_stb   <= 1'b0;
      r_z     <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        ST_GET_A: begin
          r_ack <= !(r_ack && input_a_stb);
          if (r_ack && input_a_stb) begin
            r_a   <= input_a;
            r_uns <= input_a_unsigned;
          end
        end
        ST_UNPACK: begin
          r_e <= $signed({1'b0, w_exp}) - BIAS;
          r_m <= w_ext[EXT+1 -: INT_W];
          r_r <= w_ext[EXT+1-INT_W];
          r_s <= |w_ext[EXT-INT_W:0];
        end
        ST_SPECIAL: begin
          if (w_special) begin
            r_z     <= w_sp_z;
            r_flags <= w_sp_flags;
          end
        end
        ST_CONVERT: begin
          if (r_e < E_TOP) begin
            r_m <= r_m >> 1;
            r_r <= r_m[0];
            r_s <= r_s | r_r;
            r_e <= r_e + E_ONE;
          end
        end
        ST_ROUND: begin
          r_z     <= w_rd_z;
          r_flags <= w_rd_flags;
        end
        ST_PUT_Z: r_stb <= !(r_stb && output_z_ack);
        default: ;
      endcase
    end
  end

  assign input_a_ack    = r_ack;
  assign output_z_stb   = r_stb;
  assign output_z       = r_z;
  assign output_z_flags = r_flags;

endmodule

// File: tb/tb_float_to_int_conv.sv
// tb/tb_float_to_int_conv.sv - self-checking bench for float_to_int_conv (double and single configs)
module tb_float_to_int_conv;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
`ifdef FLOAT_TO_INT_RNE_EN
  localparam logic [63:0] Z_1P5  = 64'd2;
  localparam logic [63:0] Z_0P75 = 64'd1;
`else
  localparam logic [63:0] Z_1P5  = 64'd1;
  localparam logic [63:0] Z_0P75 = 64'd0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [63:0] input_a;
  logic        input_a_unsigned, input_a_stb, input_a_ack;
  logic [63:0] output_z;
  logic [1:0]  output_z_flags;
  logic        output_z_stb, output_z_ack;

  logic [31:0] a32;
  logic        u32, stb32, ack32;
  logic [31:0] z32;
  logic [1:0]  f32;
  logic        zstb32, zack32;

  float_to_int_conv dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_unsigned(input_a_unsigned),
    .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .output_z(output_z), .output_z_flags(output_z_flags),
    .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  float_to_int_conv #(.EXP_W(8), .MAN_W(23), .INT_W(32)) dut32 (
    .clk(clk), .rst(rst),
    .input_a(a32), .input_a_unsigned(u32),
    .input_a_stb(stb32), .input_a_ack(ack32),
    .output_z(z32), .output_z_flags(f32),
    .output_z_stb(zstb32), .output_z_ack(zack32)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: exact value (1.frac) * 2^(e-52) split into integer part and remainder.
  function automatic void model(input logic [63:0] a, input logic u,
                                output logic [63:0] z, output logic [1:0] f, output int lat);
    logic sign, inx;
    int e, sh;
    logic [51:0] fr;
    logic [127:0] m, ip, rem, half;
    logic [63:0] sat;
    sign = a[63];
    fr   = a[51:0];
    e    = int'(a[62:52]) - 1023;
    sat  = sign ? (u ? 64'd0 : MIN64) : (u ? '1 : MAX64);
    lat  = 3;
    f    = 2'b00;
    z    = 64'd0;
    if (a[62:52] == 11'h7FF) begin
      z = (fr != 0) ? (u ? 64'd0 : MIN64) : sat;
      f = 2'b10;
    end else if (a[62:52] == 11'h000) begin
      f = {1'b0, fr != 0};
    end else if (e > 63) begin
      z = sat;
      f = 2'b10;
    end else if (e < -1) begin
      f = 2'b01;
    end else begin
      lat = 68 - e;
      m   = {75'd0, 1'b1, fr};
      if (e >= 52) begin
        ip = m << (e - 52); rem = 0; half = 1;
      end else begin
        sh   = 52 - e;
        ip   = m >> sh;
        rem  = m & ((128'd1 << sh) - 1);
        half = 128'd1 << (sh - 1);
      end
      inx = (rem != 0);
`ifdef FLOAT_TO_INT_RNE_EN
      if (rem > half || (rem == half && ip[0])) ip = ip + 1;
`endif
      if (!u && ((!sign && ip > {64'd0, MAX64}) || (sign && ip > {64'd0, MIN64}))) begin
        z = sat; f = 2'b10;
      end else if (u && sign && ip != 0) begin
        z = 64'd0; f = 2'b10;
      end else if (u && ip > {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
        z = sat; f = 2'b10;
      end else begin
        z = sign ? (64'd0 - ip[63:0]) : ip[63:0];
        f = {1'b0, inx};
      end
    end
  endfunction

  // Called at a negedge. hold = cycles to keep output_z_ack low once the result is up.
  task automatic run_op(input logic [63:0] a, input logic u, input int hold,
                        output logic [63:0] z, output logic [1:0] f, output int lat);
    int n;
    z = 'x; f = 'x; lat = -1;
    input_a = a; input_a_unsigned = u; input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 200) begin @(negedge clk); n++; end
    if (!input_a_ack) begin
      check("accept_timeout", input_a_ack, 1); input_a_stb = 1'b0; return;
    end
    @(negedge clk);
    input_a_stb = 1'b0;
    lat = 0;
    while (!output_z_stb && lat < 200) begin @(negedge clk); lat++; end
    if (!output_z_stb) begin check("result_timeout", output_z_stb, 1); return; end
    z = output_z; f = output_z_flags;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_z", output_z, z);
      check("hold_flags", output_z_flags, f);
      check("hold_stb", output_z_stb, 1);
      check("hold_in_ack", input_a_ack, 0);
    end
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
  endtask

  task automatic run_op32(input logic [31:0] a, input logic u,
                          output logic [31:0] z, output logic [1:0] f);
    int n;
    z = 'x; f = 'x;
    a32 = a; u32 = u; stb32 = 1'b1;
    n = 0;
    while (!ack32 && n < 200) begin @(negedge clk); n++; end
    if (!ack32) begin check("accept32_timeout", ack32, 1); stb32 = 1'b0; return; end
    @(negedge clk);
    stb32 = 1'b0;
    n = 0;
    while (!zstb32 && n < 200) begin @(negedge clk); n++; end
    if (!zstb32) begin check("result32_timeout", zstb32, 1); return; end
    z = z32; f = f32;
    zack32 = 1'b1;
    @(negedge clk);
    zack32 = 1'b0;
  endtask

  typedef struct packed {
    logic [63:0] a;
    logic        u;
    logic [63:0] z;
    logic [1:0]  f;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic        u;
    logic [31:0] z;
    logic [1:0]  f;
  } vec32_t;

  initial begin
    vec_t        vecs [15];
    vec32_t      v32 [4];
    logic [63:0] z, mz, rnd, a;
    logic [31:0] zs;
    logic [1:0]  f, mf;
    logic [10:0] ex;
    logic [51:0] fr, mask;
    logic        u;
    int          lat, mlat;

    vecs[0]  = '{64'h3FF8_0000_0000_0000, 1'b0, Z_1P5, 2'b01};
    vecs[1]  = '{64'h4004_0000_0000_0000, 1'b0, 64'd2, 2'b01};
    vecs[2]  = '{64'hBFF0_0000_0000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00};
    vecs[3]  = '{64'hBFF0_0000_0000_0000, 1'b1, 64'd0, 2'b10};
    vecs[4]  = '{64'h7FF8_0000_0000_0000, 1'b0, MIN64, 2'b10};
    vecs[5]  = '{64'h43E0_0000_0000_0000, 1'b0, MAX64, 2'b10};
    vecs[6]  = '{64'h43E0_0000_0000_0000, 1'b1, MIN64, 2'b00};
    vecs[7]  = '{64'hC3E0_0000_0000_0000, 1'b0, MIN64, 2'b00};
    vecs[8]  = '{64'h0000_0000_0000_0001, 1'b0, 64'd0, 2'b01};
    vecs[9]  = '{64'h8000_0000_0000_0000, 1'b1, 64'd0, 2'b00};
    vecs[10] = '{64'hFFF0_0000_0000_0000, 1'b0, MIN64, 2'b10};
    vecs[11] = '{64'h7FF0_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10};
    vecs[12] = '{64'h4008_0000_0000_0000, 1'b0, 64'd3, 2'b00};
    vecs[13] = '{64'h3FE8_0000_0000_0000, 1'b0, Z_0P75, 2'b01};
    vecs[14] = '{64'h3FD0_0000_0000_0000, 1'b0, 64'd0, 2'b01};

    v32[0] = '{32'h4F00_0000, 1'b0, 32'h7FFF_FFFF, 2'b10};
    v32[1] = '{32'h4040_0000, 1'b0, 32'd3, 2'b00};
    v32[2] = '{32'hBF80_0000, 1'b0, 32'hFFFF_FFFF, 2'b00};
    v32[3] = '{32'h3FC0_0000, 1'b1, Z_1P5[31:0], 2'b01};

    rst = 1'b1;
    input_a = '0; input_a_unsigned = 1'b0; input_a_stb = 1'b0; output_z_ack = 1'b0;
    a32 = '0; u32 = 1'b0; stb32 = 1'b0; zack32 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ack", input_a_ack, 0);
    check("reset_out_stb", output_z_stb, 0);
    check("reset_z", output_z, 0);
    check("reset_flags", output_z_flags, 0);
    check("reset32_out_stb", zstb32, 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].a, vecs[i].u, 0, z, f, lat);
      model(vecs[i].a, vecs[i].u, mz, mf, mlat);
      check($sformatf("vec%0d_z", i), z, vecs[i].z);
      check($sformatf("vec%0d_flags", i), f, vecs[i].f);
      check($sformatf("vec%0d_latency", i), lat, mlat);
    end

    // Consumer stalls: result must hold and no new operand may be accepted.
    run_op(64'h3FF8_0000_0000_0000, 1'b0, 5, z, f, lat);
    check("stall_z", z, Z_1P5);
    check("stall_flags", f, 2'b01);
    run_op(64'h4008_0000_0000_0000, 1'b0, 0, z, f, lat);
    check("after_stall_z", z, 3);

    // Reset in the middle of a long CONVERT sequence.
    input_a = 64'h3FF0_0000_0000_0000; input_a_unsigned = 1'b0; input_a_stb = 1'b1;
    for (int n = 0; n < 200 && !input_a_ack; n++) @(negedge clk);
    check("midrst_accept", input_a_ack, 1);
    @(negedge clk);
    input_a_stb = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ack", input_a_ack, 0);
    check("midrst_out_stb", output_z_stb, 0);
    rst = 1'b0;
    run_op(64'h4008_0000_0000_0000, 1'b0, 0, z, f, lat);
    check("postrst_z", z, 3);
    check("postrst_flags", f, 2'b00);
    check("postrst_latency", lat, 67);

    for (int i = 0; i < 4; i++) begin
      run_op32(v32[i].a, v32[i].u, zs, f);
      check($sformatf("sp%0d_z", i), zs, v32[i].z);
      check($sformatf("sp%0d_flags", i), f, v32[i].f);
    end

    for (int i = 0; i < 250; i++) begin
      rnd = {$urandom, $urandom};
      fr  = rnd[51:0];
      case ($urandom_range(0, 9))
        0:       ex = 11'h7FF;
        1:       ex = 11'h000;
        default: ex = 11'(1018 + $urandom_range(0, 70));
      endcase
      if ($urandom_range(0, 2) == 0) begin
        mask = '1;
        mask = mask << $urandom_range(0, 52);
        fr   = fr & mask;
      end
      a = {1'($urandom_range(0, 1)), ex, fr};
      u = 1'($urandom_range(0, 1));
      run_op(a, u, 0, z, f, lat);
      model(a, u, mz, mf, mlat);
      check($sformatf("rand_z a=%h u=%0d", a, u), z, mz);
      check($sformatf("rand_flags a=%h u=%0d", a, u), f, mf);
      check($sformatf("rand_latency a=%h", a), lat, mlat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
